// File: rtl/decode_ibuf_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_ibuf_if : fetch-side and decode-side handshake bundle of decode_ibuf
// Revision 1.0
// ---------------------------------------------------------------------------
interface decode_ibuf_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_pc;
  logic [31:0]        in_ir;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [31:0]        out_ir;
  logic               out_op_ld;
  logic               out_op_st;
  logic               out_op_ldr;
  logic               out_op_jmp;
  logic               out_op_beq;
  logic               out_op_bne;
  logic               out_op;
  logic               out_opc;
  logic               out_illegal;
  logic [c_cnt_w-1:0] out_count;
  logic               out_afull;
  logic               flush;

  modport slave (
    input  in_valid, in_pc, in_ir, out_ready, flush,
    output in_ready, out_valid, out_pc, out_ir,
           out_op_ld, out_op_st, out_op_ldr, out_op_jmp, out_op_beq, out_op_bne,
           out_op, out_opc, out_illegal, out_count, out_afull
  );

  modport master (
    output in_valid, in_pc, in_ir, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_ir,
           out_op_ld, out_op_st, out_op_ldr, out_op_jmp, out_op_beq, out_op_bne,
           out_op, out_opc, out_illegal, out_count, out_afull
  );
endinterface
`default_nettype wire

// File: rtl/decode_ibuf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_ibuf : fetch-to-decode instruction queue with registered pre-decode
// Revision 1.0
// ---------------------------------------------------------------------------
module decode_ibuf #(
  parameter int          XLEN      = 32,
  parameter int          DEPTH     = 4,
  parameter int          AFULL_LVL = 3,
  parameter logic [31:0] NOP_INST  = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst,
  decode_ibuf_if.slave  bus
);
  localparam int                  c_ptr_w = $clog2(DEPTH);
  localparam int                  c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_cnt_w-1:0]  c_full  = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0]  c_afull = c_cnt_w'(AFULL_LVL);
  localparam logic [c_ptr_w-1:0]  c_ptr_one = c_ptr_w'(1);

  // Pre-decode bit positions inside each stored entry
  localparam int c_pd_ld  = 8;
  localparam int c_pd_st  = 7;
  localparam int c_pd_ldr = 6;
  localparam int c_pd_jmp = 5;
  localparam int c_pd_beq = 4;
  localparam int c_pd_bne = 3;
  localparam int c_pd_op  = 2;
  localparam int c_pd_opc = 1;
  localparam int c_pd_ill = 0;

  logic [c_ptr_w-1:0] r_wp;
  logic [c_ptr_w-1:0] r_rp;
  logic [c_cnt_w-1:0] r_count;
  logic [XLEN-1:0]    r_pc [DEPTH];
  logic [31:0]        r_ir [DEPTH];
  logic [8:0]         r_pd [DEPTH];

  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [5:0]         w_opcode;
  logic               w_alu_fn;
  logic [8:0]         w_pd;
  logic [8:0]         w_head_pd;

  assign w_empty      = (r_count == '0);
  assign bus.in_ready = (r_count != c_full);
  assign w_push       = bus.in_valid && bus.in_ready && !bus.flush;
  assign w_pop        = !w_empty && bus.out_ready && !bus.flush;
  assign w_opcode     = bus.in_ir[31:26];

  // ALU function codes shared by register and constant forms (low 4 bits)
  always_comb begin
    w_alu_fn = 1'b0;
    case (w_opcode[3:0])
      4'h0, 4'h1, 4'h4, 4'h5, 4'h6,
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: w_alu_fn = 1'b1;
      default:                                   w_alu_fn = 1'b0;
    endcase
  end

  always_comb begin
    w_pd           = '0;
    w_pd[c_pd_ld]  = (w_opcode == 6'b011000);
    w_pd[c_pd_st]  = (w_opcode == 6'b011001);
    w_pd[c_pd_jmp] = (w_opcode == 6'b011011);
    w_pd[c_pd_beq] = (w_opcode == 6'b011100);
    w_pd[c_pd_bne] = (w_opcode == 6'b011101);
    w_pd[c_pd_ldr] = (w_opcode == 6'b011111);
    w_pd[c_pd_op]  = (w_opcode[5:4] == 2'b10) && w_alu_fn;
    w_pd[c_pd_opc] = (w_opcode[5:4] == 2'b11) && w_alu_fn;
    w_pd[c_pd_ill] = ~|w_pd[8:1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + c_ptr_one;
      if (w_pop)  r_rp <= r_rp + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload is never reset; the empty mask below hides stale contents
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wp] <= bus.in_pc;
      r_ir[r_wp] <= bus.in_ir;
      r_pd[r_wp] <= w_pd;
    end
  end

  assign w_head_pd       = w_empty ? 9'd0 : r_pd[r_rp];
  assign bus.out_valid   = !w_empty;
  assign bus.out_pc      = w_empty ? '0 : r_pc[r_rp];
  assign bus.out_ir      = w_empty ? NOP_INST : r_ir[r_rp];
  assign bus.out_op_ld   = w_head_pd[c_pd_ld];
  assign bus.out_op_st   = w_head_pd[c_pd_st];
  assign bus.out_op_ldr  = w_head_pd[c_pd_ldr];
  assign bus.out_op_jmp  = w_head_pd[c_pd_jmp];
  assign bus.out_op_beq  = w_head_pd[c_pd_beq];
  assign bus.out_op_bne  = w_head_pd[c_pd_bne];
  assign bus.out_op      = w_head_pd[c_pd_op];
  assign bus.out_opc     = w_head_pd[c_pd_opc];
  assign bus.out_illegal = w_head_pd[c_pd_ill];
  assign bus.out_count   = r_count;
  assign bus.out_afull   = (r_count >= c_afull);

endmodule
`default_nettype wire

// File: tb/tb_decode_ibuf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_decode_ibuf : directed vector table plus multi-cycle sequences
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_decode_ibuf;
  localparam logic [31:0] c_nop = 32'h8000_0000;
  // Flag order: {ld, st, ldr, jmp, beq, bne, op, opc, illegal}
  localparam logic [8:0] c_f0  = 9'b000000000;
  localparam logic [8:0] c_ld  = 9'b100000000;
  localparam logic [8:0] c_st  = 9'b010000000;
  localparam logic [8:0] c_ldr = 9'b001000000;
  localparam logic [8:0] c_jmp = 9'b000100000;
  localparam logic [8:0] c_beq = 9'b000010000;
  localparam logic [8:0] c_bne = 9'b000001000;
  localparam logic [8:0] c_op  = 9'b000000100;
  localparam logic [8:0] c_opc = 9'b000000010;
  localparam logic [8:0] c_ill = 9'b000000001;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        ordy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eir;
    logic [8:0]  ef;
    logic [2:0]  ecnt;
    logic        eaf;
    logic        erdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl [22];

  decode_ibuf_if #(.XLEN(32), .DEPTH(4)) bus ();

  decode_ibuf #(
    .XLEN(32), .DEPTH(4), .AFULL_LVL(3), .NOP_INST(32'h8000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] ir,
                       input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_ir     = ir;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic [31:0] epc,
                            input logic [31:0] eir, input logic [8:0] ef,
                            input logic [2:0] ecnt, input logic eaf, input logic erdy);
    logic [8:0] f;
    f = {bus.out_op_ld, bus.out_op_st, bus.out_op_ldr, bus.out_op_jmp, bus.out_op_beq,
         bus.out_op_bne, bus.out_op, bus.out_opc, bus.out_illegal};
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'(ev));
    chk({tag, ".pc"},    64'(bus.out_pc),    64'(epc));
    chk({tag, ".ir"},    64'(bus.out_ir),    64'(eir));
    chk({tag, ".flags"}, 64'(f),             64'(ef));
    chk({tag, ".count"}, 64'(bus.out_count), 64'(ecnt));
    chk({tag, ".afull"}, 64'(bus.out_afull), 64'(eaf));
    chk({tag, ".ready"}, 64'(bus.in_ready),  64'(erdy));
  endtask

  // Drive at the falling edge, check 1 ns later; the rising edge then commits
  task automatic step(input string tag, input logic iv, input logic [31:0] pc,
                      input logic [31:0] ir, input logic ordy, input logic fl,
                      input logic ev, input logic [31:0] epc, input logic [31:0] eir,
                      input logic [8:0] ef, input logic [2:0] ecnt, input logic eaf,
                      input logic erdy);
    @(negedge clk);
    drive(iv, pc, ir, ordy, fl);
    #1;
    expect_out(tag, ev, epc, eir, ef, ecnt, eaf, erdy);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 32'h00, 32'h0000_0000, 1'b0, 1'b0, 32'h00, c_nop,         c_f0,  3'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 32'h04, 32'h6000_0000, 1'b0, 1'b0, 32'h00, c_nop,         c_f0,  3'd0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 32'h08, 32'h6400_0000, 1'b0, 1'b1, 32'h04, 32'h6000_0000, c_ld,  3'd1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 32'h0C, 32'h8000_0000, 1'b0, 1'b1, 32'h04, 32'h6000_0000, c_ld,  3'd2, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 32'h10, 32'hC000_0000, 1'b0, 1'b1, 32'h04, 32'h6000_0000, c_ld,  3'd3, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 32'h14, 32'h7400_0000, 1'b0, 1'b1, 32'h04, 32'h6000_0000, c_ld,  3'd4, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 32'h00, 32'h0000_0000, 1'b1, 1'b1, 32'h04, 32'h6000_0000, c_ld,  3'd4, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 32'h00, 32'h0000_0000, 1'b1, 1'b1, 32'h08, 32'h6400_0000, c_st,  3'd3, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 32'h00, 32'h0000_0000, 1'b1, 1'b1, 32'h0C, 32'h8000_0000, c_op,  3'd2, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 32'h00, 32'h0000_0000, 1'b1, 1'b1, 32'h10, 32'hC000_0000, c_opc, 3'd1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 32'h14, 32'h7400_0000, 1'b0, 1'b0, 32'h00, c_nop,         c_f0,  3'd0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 32'h18, 32'h6C00_0000, 1'b0, 1'b1, 32'h14, 32'h7400_0000, c_bne, 3'd1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 32'h1C, 32'h0000_0000, 1'b1, 1'b1, 32'h14, 32'h7400_0000, c_bne, 3'd2, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 32'h20, 32'h7C00_0000, 1'b1, 1'b1, 32'h18, 32'h6C00_0000, c_jmp, 3'd2, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 32'h24, 32'h7000_0000, 1'b1, 1'b1, 32'h1C, 32'h0000_0000, c_ill, 3'd2, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 32'h28, 32'h8800_0000, 1'b1, 1'b1, 32'h20, 32'h7C00_0000, c_ldr, 3'd2, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 32'h2C, 32'hF800_0000, 1'b1, 1'b1, 32'h24, 32'h7000_0000, c_beq, 3'd2, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 32'h30, 32'hBC00_0000, 1'b1, 1'b1, 32'h28, 32'h8800_0000, c_ill, 3'd2, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 32'h34, 32'hA000_0000, 1'b1, 1'b1, 32'h2C, 32'hF800_0000, c_opc, 3'd2, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 32'h00, 32'h0000_0000, 1'b1, 1'b1, 32'h30, 32'hBC00_0000, c_ill, 3'd2, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 32'h00, 32'h0000_0000, 1'b1, 1'b1, 32'h34, 32'hA000_0000, c_op,  3'd1, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 32'h00, 32'h0000_0000, 1'b0, 1'b0, 32'h00, c_nop,         c_f0,  3'd0, 1'b0, 1'b1};

    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    expect_out("reset", 1'b0, 32'h0, c_nop, c_f0, 3'd0, 1'b0, 1'b1);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      step($sformatf("row%0d", i), tbl[i].iv, tbl[i].pc, tbl[i].ir, tbl[i].ordy, 1'b0,
           tbl[i].ev, tbl[i].epc, tbl[i].eir, tbl[i].ef, tbl[i].ecnt, tbl[i].eaf, tbl[i].erdy);
    end

    // Flush at count=3 with a concurrent push and pop
    step("fl_p0", 1'b1, 32'h100, 32'h8000_0100, 1'b0, 1'b0, 1'b0, 32'h0, c_nop, c_f0, 3'd0, 1'b0, 1'b1);
    step("fl_p1", 1'b1, 32'h104, 32'h8000_0104, 1'b0, 1'b0, 1'b1, 32'h100, 32'h8000_0100, c_op, 3'd1, 1'b0, 1'b1);
    step("fl_p2", 1'b1, 32'h108, 32'h8000_0108, 1'b0, 1'b0, 1'b1, 32'h100, 32'h8000_0100, c_op, 3'd2, 1'b0, 1'b1);
    step("fl_go", 1'b1, 32'h10C, 32'h8000_010C, 1'b1, 1'b1, 1'b1, 32'h100, 32'h8000_0100, c_op, 3'd3, 1'b1, 1'b1);
    step("fl_after", 1'b1, 32'h200, 32'h6000_0000, 1'b0, 1'b0, 1'b0, 32'h0, c_nop, c_f0, 3'd0, 1'b0, 1'b1);
    step("fl_push", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h6000_0000, c_ld, 3'd1, 1'b0, 1'b1);
    step("fl_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h6000_0000, c_ld, 3'd1, 1'b0, 1'b1);
    step("fl_empty", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, c_nop, c_f0, 3'd0, 1'b0, 1'b1);

    // Steady push+pop at count=2; pointers wrap several times
    step("st_p0", 1'b1, 32'h4, 32'h8000_0004, 1'b0, 1'b0, 1'b0, 32'h0, c_nop, c_f0, 3'd0, 1'b0, 1'b1);
    step("st_p1", 1'b1, 32'h8, 32'h8000_0008, 1'b0, 1'b0, 1'b1, 32'h4, 32'h8000_0004, c_op, 3'd1, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      logic [31:0] npc;
      logic [31:0] hpc;
      npc = 32'(4 * (k + 3));
      hpc = 32'(4 * (k + 1));
      step($sformatf("st%0d", k), 1'b1, npc, 32'h8000_0000 | npc, 1'b1, 1'b0,
           1'b1, hpc, 32'h8000_0000 | hpc, c_op, 3'd2, 1'b0, 1'b1);
    end
    step("st_d0", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h2C, 32'h8000_002C, c_op, 3'd2, 1'b0, 1'b1);
    step("st_d1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h30, 32'h8000_0030, c_op, 3'd1, 1'b0, 1'b1);
    step("st_d2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, c_nop, c_f0, 3'd0, 1'b0, 1'b1);

    // Asynchronous reset between clock edges while holding two entries
    step("rs_p0", 1'b1, 32'h300, 32'h6000_0000, 1'b0, 1'b0, 1'b0, 32'h0, c_nop, c_f0, 3'd0, 1'b0, 1'b1);
    step("rs_p1", 1'b1, 32'h304, 32'h6400_0000, 1'b0, 1'b0, 1'b1, 32'h300, 32'h6000_0000, c_ld, 3'd1, 1'b0, 1'b1);
    step("rs_hold", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h300, 32'h6000_0000, c_ld, 3'd2, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1;
    expect_out("rs_async", 1'b0, 32'h0, c_nop, c_f0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    step("rs_post", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, c_nop, c_f0, 3'd0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
